// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage instruction, long-unit completion and hazard/forward control bundle.
interface hazard_scoreboard_if #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int FWD_W      = $clog2(FWD_STAGES + 1)
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd, long_rd;
  logic              id_use_rs1, id_use_rs2, id_regwrite, id_is_load, id_is_long;
  logic              long_done, flush;
  logic              stall, issue, long_busy;
  logic [FWD_W-1:0]  fwd_a, fwd_b;
  logic [15:0]       stall_count;
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite,
           id_is_load, id_is_long, long_done, long_rd, flush,
    input  stall, issue, fwd_a, fwd_b, long_busy, stall_count
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite,
           id_is_load, id_is_long, long_done, long_rd, flush,
    output stall, issue, fwd_a, fwd_b, long_busy, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown/age scoreboard driving stall, issue and EX forward selects.
module hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int FWD_W      = $clog2(FWD_STAGES + 1),
  parameter int LOAD_LAT   = 1,
  parameter int ALU_LAT    = 0,
  parameter int CNT_W      = 4
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave bus
);
  localparam int NREGS = 2 ** REG_AW;
  localparam int AGE_W = $clog2(FWD_STAGES + 2);
  localparam logic [CNT_W-1:0] LONG = '1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(FWD_STAGES + 1);
  logic [CNT_W-1:0] r_cnt [NREGS];
  logic [AGE_W-1:0] r_age [NREGS];
  logic             r_long_busy;
  logic [15:0]      r_stall_count;
  logic [FWD_W-1:0] r_fwd_a, r_fwd_b;
  logic             w_blk1, w_blk2, w_waw, w_stall, w_issue, w_write;
  logic [CNT_W-1:0] w_lat;
  logic [FWD_W-1:0] w_sel_a, w_sel_b;
  always_comb begin
    w_blk1  = bus.id_use_rs1 && bus.id_rs1 != '0 && r_cnt[bus.id_rs1] != '0;
    w_blk2  = bus.id_use_rs2 && bus.id_rs2 != '0 && r_cnt[bus.id_rs2] != '0;
    w_waw   = bus.id_regwrite && bus.id_rd != '0 && r_cnt[bus.id_rd] == LONG;
    w_stall = bus.id_valid && !bus.flush && (w_blk1 || w_blk2 || w_waw || (bus.id_is_long && r_long_busy));
    w_issue = bus.id_valid && !w_stall && !bus.flush;
    w_write = w_issue && bus.id_regwrite && bus.id_rd != '0;
    w_lat   = bus.id_is_long ? LONG : bus.id_is_load ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
    w_sel_a = (bus.id_use_rs1 && bus.id_rs1 != '0 && r_age[bus.id_rs1] < AGE_W'(FWD_STAGES))
              ? FWD_W'(r_age[bus.id_rs1] + AGE_W'(1)) : '0;
    w_sel_b = (bus.id_use_rs2 && bus.id_rs2 != '0 && r_age[bus.id_rs2] < AGE_W'(FWD_STAGES))
              ? FWD_W'(r_age[bus.id_rs2] + AGE_W'(1)) : '0;
  end
  // Long results are read from the register file, so completion retires the entry outright.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        r_cnt[r] <= '0;
        r_age[r] <= AGE_MAX;
      end
      r_long_busy   <= 1'b0;
      r_stall_count <= '0;
      r_fwd_a       <= '0;
      r_fwd_b       <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (bus.long_done && bus.long_rd == REG_AW'(r)) begin
          r_cnt[r] <= '0;
          r_age[r] <= AGE_MAX;
        end else if (w_write && bus.id_rd == REG_AW'(r)) begin
          r_cnt[r] <= w_lat;
          r_age[r] <= '0;
        end else begin
          if (r_cnt[r] != '0 && r_cnt[r] != LONG) r_cnt[r] <= r_cnt[r] - CNT_W'(1);
          if (r_age[r] < AGE_MAX) r_age[r] <= r_age[r] + AGE_W'(1);
        end
      end
      if (bus.long_done) r_long_busy <= 1'b0;
      if (w_issue && bus.id_is_long) r_long_busy <= 1'b1;
      if (w_stall && r_stall_count != 16'hFFFF) r_stall_count <= r_stall_count + 16'd1;
      r_fwd_a <= w_issue ? w_sel_a : '0;
      r_fwd_b <= w_issue ? w_sel_b : '0;
    end
  end
  long_done_pending: assert property (@(posedge clk) disable iff (!rst)
    bus.long_done |-> r_cnt[bus.long_rd] == LONG);
  assign bus.stall       = w_stall;
  assign bus.issue       = w_issue;
  assign bus.fwd_a       = r_fwd_a;
  assign bus.fwd_b       = r_fwd_b;
  assign bus.long_busy   = r_long_busy;
  assign bus.stall_count = r_stall_count;
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard and forwarding controller for the 5-stage RISC pipeline. It replaces the fixed load-use hazard check and the EX-stage forwarding logic. It tracks outstanding register writes with per-register countdown and age state, and generalises to configurable load latency and forward-path depth. It adds tracking for one outstanding multi-cycle (mul/div) unit and a stall performance counter.

Parameters:
REG_AW, 5, register address width; NREGS = 2**REG_AW.
FWD_STAGES, 2, number of post-EX forward sources (1 = EX/MEM, 2 = MEM/WB, ...).
FWD_W, $clog2(FWD_STAGES+1), forward select width (derived).
LOAD_LAT, 1, stall cycles a dependent instruction must wait after a load issues.
ALU_LAT, 0, stall cycles after an ALU writer issues.
CNT_W, 4, countdown width; LOAD_LAT and ALU_LAT must both be < 2**CNT_W - 1.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
id_valid  in  1  valid instruction in ID
id_rs1, id_rs2  in  REG_AW  source registers
id_use_rs1, id_use_rs2  in  1  source actually read
id_rd  in  REG_AW  destination register
id_regwrite  in  1  instruction writes rd
id_is_load  in  1  load instruction
id_is_long  in  1  multi-cycle unit instruction
long_done  in  1  one-cycle pulse: long result written to register file this cycle
long_rd  in  REG_AW  destination of the completing long op
flush  in  1  taken branch in ID; squash ID instruction
stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
issue  out  1  ID instruction advances to EX this edge
fwd_a, fwd_b  out  FWD_W  EX-stage operand select: 0 = register file, k = k-th post-EX stage
long_busy  out  1  long unit occupied
stall_count  out  16  saturating count of stall cycles

Behaviour:
- Reset (rst=0, async): every cnt[r]=0, every age[r]=FWD_STAGES+1, long_busy=0, fwd_a=fwd_b=0, stall_count=0.
- Register x0 is never tracked: writes to rd=0 are ignored, and reads of x0 never cause a stall and always give fwd=0.
- Blocked source: source s is blocked if id_use_s=1, s!=0, and cnt[s]!=0.
- Stall (combinational): stall = id_valid & !flush & (any source blocked | (id_regwrite & id_rd!=0 & cnt[id_rd]==LONG) | (id_is_long & long_busy)).
  - LONG is the all-ones value of CNT_W.
- Issue (combinational): issue = id_valid & !stall & !flush. Flush has priority: when flush=1, stall=0 and issue=0.
- Each clock edge:
  - Every cnt[r] not equal to 0 or LONG decrements by 1.
  - Every age[r] below FWD_STAGES+1 increments by 1.
- On issue with id_regwrite & id_rd!=0:
  - cnt[id_rd] <= LONG if id_is_long; LOAD_LAT if id_is_load; otherwise ALU_LAT.
  - age[id_rd] <= 0. This overrides that edge's decrement and increment.
- On issue with id_is_long: long_busy <= 1.
- On long_done:
  - cnt[long_rd] <= 0, age[long_rd] <= FWD_STAGES+1, long_busy <= 0.
  - A long_rd that is not LONG-pending is a protocol error; assert in simulation.
  - Long results come only from the register file (write-before-read), so a consumer may issue the cycle after long_done.
- Forward select, registered at the issue edge:
  - For each source: fwd <= age+1 if age+1 <= FWD_STAGES and the source is non-zero and used; otherwise 0.
  - The value is held for exactly the consumer's EX cycle.
  - If no issue occurs (bubble), fwd <= 0.
  - Age is the pre-edge value of the producer's age.
- Same-edge conflict: if a new writer issues to rd X in the same edge a long_done for X arrives, this cannot occur (the WAW stall blocks the writer). If long_done coincides with issue of a different register, both updates apply.
- stall_count increments on every cycle with stall=1 and saturates at 16'hFFFF.
- Reset asserted mid-operation clears all state immediately; outstanding long ops are forgotten, and long_done arriving after reset is ignored.

Test Plan:
- Load-use: issue lw x5 (LOAD_LAT=1); the next cycle ID holds add x6,x5,x1 -> stall=1 for exactly 1 cycle, then issue=1 with fwd_a=2 registered.
- ALU chain: add x3 issues, then sub x4,x3,x3 in the following cycle -> no stall; fwd_a=fwd_b=1. A third instruction reading x3 two cycles later gets fwd=2; three cycles later it gets fwd=0.
- Long op: mul x7 issues; the reader of x7 stalls until long_done with long_rd=7; it issues the cycle after with fwd_a=0. A second mul while long_busy=1 stalls, and the WAW writer to x7 stalls.
- Flush priority: a load-use stall condition with flush=1 in the same cycle -> stall=0, issue=0, no scoreboard change, stall_count unchanged.
- x0 and unused sources: lw x0, then a reader of x0; an instruction with id_use_rs2=0 and rs2 matching a pending load -> no stall, fwd=0.
- Async reset: assert rst=0 mid-cycle while a long op is pending and stall=1 -> stall, long_busy, fwd_a, fwd_b and stall_count all 0 immediately. Force stall_count to saturate -> it holds at 65535.
